// File: rtl/rs232_avm_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rs232_avm_responder_if
// Description : Avalon-MM bus bundle between the RSA wrapper master and the
//               RS232 register-map responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs232_avm_responder_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata,
    input  avs_waitrequest
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata,
    output avs_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/rs232_avm_responder.sv
`default_nettype none
// ============================================================================
// Module      : rs232_avm_responder
// Description : Avalon-MM slave modelling the RS232 UART register map
//               (RX data 0x00, TX data 0x04, STATUS 0x08) with host-side RX
//               and TX byte FIFOs and programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_avm_responder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 avm_clk,
  input  logic                 avm_rst,
  rs232_avm_responder_if.slave avs,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_tx_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [4:0]  c_addr_rx     = 5'd0;
  localparam logic [4:0]  c_addr_tx     = 5'd4;
  localparam logic [4:0]  c_addr_status = 5'd8;
  // Last count value in WAIT; unused when WAIT_CYCLES is 0 (WAIT is skipped)
  localparam logic [3:0]  c_wait_last   = 4'(WAIT_CYCLES - 1);
  localparam logic [AW:0] c_ptr_one     = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic [4:0]  r_addr;
  logic        r_is_read;
  logic        r_is_write;
  logic        r_waitreq;

  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_rx_wr;
  logic [AW:0] r_rx_rd;
  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wr;
  logic [AW:0] r_tx_rd;
  logic        r_tx_overflow;

  logic        w_done;
  logic        w_rx_empty;
  logic        w_rx_full;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic [7:0]  w_rx_head;
  logic        w_tx_empty;
  logic        w_tx_full;
  logic        w_tx_wr_sel;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic [31:0] w_readdata;
  logic        w_unused;

  // Only the low byte of a write carries data
  assign w_unused = &{1'b0, avs.avs_writedata[31:8]};

  // Access sequencer: latch request in IDLE, count wait states, complete in DONE
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= 5'd0;
      r_is_read  <= 1'b0;
      r_is_write <= 1'b0;
      r_waitreq  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_waitreq <= 1'b1;
          if (avs.avs_read || avs.avs_write) begin
            r_addr     <= avs.avs_address;
            r_is_read  <= avs.avs_read;
            // A simultaneous read and write is serviced as a read only
            r_is_write <= avs.avs_write & ~avs.avs_read;
            r_wait_cnt <= 4'd0;
            if (WAIT_CYCLES == 0) begin
              r_state   <= S_DONE;
              r_waitreq <= 1'b0;
            end else begin
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == c_wait_last) begin
            r_state   <= S_DONE;
            r_waitreq <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_DONE: begin
          // Requests still held here belong to this access; never restart
          r_state   <= S_IDLE;
          r_waitreq <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_waitreq <= 1'b1;
        end
      endcase
    end
  end

  assign w_done = (r_state == S_DONE);

  // RX FIFO status and control
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) &&
                      (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
  assign w_rx_push  = i_rx_valid && !w_rx_full;
  assign w_rx_pop   = w_done && r_is_read && (r_addr == c_addr_rx) && !w_rx_empty;
  assign w_rx_head  = r_rx_mem[r_rx_rd[AW-1:0]];
  assign o_rx_ready = !w_rx_full;

  // RX pointers: host pushes, master pops; both may move in one cycle
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_ptr_one;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_ptr_one;
    end
  end

  // RX storage write port
  always_ff @(posedge avm_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= i_rx_data;
  end

  // TX FIFO status and control; full check uses pre-cycle occupancy
  assign w_tx_empty  = (r_tx_wr == r_tx_rd);
  assign w_tx_full   = (r_tx_wr[AW] != r_tx_rd[AW]) &&
                       (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_tx_wr_sel = w_done && r_is_write && (r_addr == c_addr_tx);
  assign w_tx_push   = w_tx_wr_sel && !w_tx_full;
  assign w_tx_pop    = !w_tx_empty && i_tx_ready;
  assign o_tx_valid  = !w_tx_empty;
  // Head is forced to zero when empty so stale storage never shows
  assign o_tx_data   = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd[AW-1:0]];

  // TX pointers: master pushes, host pops
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_ptr_one;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_ptr_one;
    end
  end

  // TX storage write port
  always_ff @(posedge avm_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= avs.avs_writedata[7:0];
  end

  // Sticky overflow: a TX write found the FIFO full and its byte was dropped
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_tx_overflow <= 1'b0;
    end else if (w_tx_wr_sel && w_tx_full) begin
      r_tx_overflow <= 1'b1;
    end
  end

  assign o_tx_overflow = r_tx_overflow;

  // Read data mux, driven only during the completion cycle
  always_comb begin
    w_readdata = 32'd0;
    if (w_done && r_is_read) begin
      case (r_addr)
        c_addr_rx: begin
          if (!w_rx_empty) w_readdata = {24'd0, w_rx_head};
        end
        c_addr_status: begin
          w_readdata[7] = !w_rx_empty;
          w_readdata[6] = !w_tx_full;
        end
        default: w_readdata = 32'd0;
      endcase
    end
  end

  assign avs.avs_readdata    = w_readdata;
  assign avs.avs_waitrequest = r_waitreq;

endmodule
`default_nettype wire

// File: doc/rs232_avm_responder.md
Name: rs232_avm_responder

Overview:
- Avalon-MM slave that models the RS232 UART register map: RX data at 0x00, TX data at 0x04, STATUS at 0x08.
- Acts as the responder end for the lab2 RSA wrapper master and is used both in simulation benches and as a stand-in for the UART IP.
- Host-side byte streams feed an RX FIFO, which the master reads, and drain a TX FIFO, which the master writes.
- Wait states are programmable so the master's waitrequest handling can be exercised.

Parameters:
- FIFO_DEPTH, 4: entries in each of the RX and TX FIFOs. Must be a power of 2 and at least 2.
- WAIT_CYCLES, 1: number of extra cycles that avs_waitrequest stays high per access. Legal range is 0 to 15.

Ports:
- avm_clk  in  1  clock.
- avm_rst  in  1  asynchronous reset, active-high.
- avs_address  in  5  byte address. Decoded values: 0 = RX, 4 = TX, 8 = STATUS.
- avs_read  in  1  read request, held by the master until completion.
- avs_readdata  out  32  read data. Valid only in the completion cycle.
- avs_write  in  1  write request, held by the master until completion.
- avs_writedata  in  32  write data. Only bits [7:0] are used.
- avs_waitrequest  out  1  low for exactly one cycle, the completion cycle. High at all other times.
- i_rx_data  in  8  host byte to be delivered to the master.
- i_rx_valid  in  1  i_rx_data is valid.
- o_rx_ready  out  1  RX FIFO is not full.
- o_tx_data  out  8  head of the TX FIFO.
- o_tx_valid  out  1  TX FIFO is not empty.
- i_tx_ready  in  1  host accepts o_tx_data.
- o_tx_overflow  out  1  sticky flag: a TX write arrived while the TX FIFO was full.

Behaviour:
- Reset values:
  - avs_waitrequest = 1, avs_readdata = 0.
  - Both FIFOs empty, so o_rx_ready = 1 and o_tx_valid = 0.
  - o_tx_data = 0, o_tx_overflow = 0, FSM in IDLE.
- Reset asserted mid-access aborts the access, flushes both FIFOs and returns all outputs to their reset values. It takes effect immediately, since reset is asynchronous.
- FSM states and transitions:
  - IDLE: waitrequest = 1. If avs_read or avs_write is high, latch the address and the operation, then go to WAIT, or to DONE when WAIT_CYCLES = 0.
  - WAIT: waitrequest = 1. Count WAIT_CYCLES cycles, then go to DONE. Request inputs are ignored in this state.
  - DONE: waitrequest = 0, the access takes effect, then go to IDLE. The request inputs seen in DONE belong to the finishing access and never start a new one.
- Timing: a request first seen high in IDLE at cycle t completes (waitrequest low) at cycle t+1+WAIT_CYCLES. Back-to-back accesses are spaced by at least one IDLE cycle.
- Simultaneous avs_read and avs_write is treated as a read; the write is discarded.
- Read from RX (address 0):
  - readdata = {24'b0, RX head}, and the RX FIFO pops in DONE.
  - If the RX FIFO is empty: readdata = 0 and no pop occurs.
- Read from STATUS (address 8):
  - readdata[7] = RX not empty.
  - readdata[6] = TX not full.
  - All other bits are 0.
  - Both bits are sampled in the DONE cycle, before that cycle's host push/pop takes effect.
- Read from TX or from an unmapped address: readdata = 0.
- Write to TX (address 4):
  - Pushes writedata[7:0] in DONE.
  - If the TX FIFO is full, the byte is dropped and o_tx_overflow is set. It stays set until reset.
- Write to any other address: ignored, but still completes with waitrequest low.
- avs_readdata returns to 0 in the cycle after DONE.
- RX FIFO:
  - Host push on i_rx_valid && o_rx_ready.
  - A push and a master pop in the same cycle are both honoured; occupancy is unchanged.
  - Push when full is impossible, because ready is low.
- TX FIFO:
  - Host pop on o_tx_valid && i_tx_ready.
  - A push and a pop in the same cycle are both honoured. When full, a same-cycle pop does NOT make room for the push: the full check uses pre-cycle occupancy.
  - o_tx_data presents the head combinationally from the registered FIFO storage.
- Pointers are log2(FIFO_DEPTH)+1 bits wide. Full/empty is determined by MSB and remainder comparison, and wrap-around is natural modulo 2*FIFO_DEPTH.
- Both FIFOs preserve byte order: the first byte in is the first byte out.

Test Plan:
- Reset, then STATUS read with WAIT_CYCLES=1 and empty FIFOs:
  - waitrequest is high for 2 cycles, low on the 3rd.
  - readdata = 0x40 (TX not full, RX empty).
- Host pushes 0xA5 and 0x3C; master performs STATUS, RX, STATUS, RX, STATUS:
  - STATUS reads return 0xC0, 0xC0, 0x40.
  - RX reads return 0x000000A5 then 0x0000003C.
- RX read with the RX FIFO empty:
  - readdata = 0.
  - FIFO state unchanged; a subsequent STATUS read still returns bit7 = 0.
- i_tx_ready = 0; master writes 0x11, 0x22, 0x33, 0x44, then 0x55:
  - After the 4th write, STATUS returns bit6 = 0.
  - The 5th write completes with waitrequest low, o_tx_overflow = 1, and 0x55 is lost.
  - After i_tx_ready = 1, o_tx_data streams 0x11, 0x22, 0x33, 0x44.
- 10 host bytes pushed through a depth-4 FIFO with interleaved RX reads, including a push and pop in the same cycle:
  - All 10 bytes read back in order.
  - Pointer wrap-around exercised with no loss or duplication.
- Reset asserted during the WAIT state of an RX read while holding 2 bytes:
  - waitrequest = 1 and o_rx_ready = 1 immediately.
  - A subsequent STATUS read returns 0x40.
